ram_burst_reader: RTL and testbench

Read-side sequencer placed directly downstream of the team's dual-port RAM read port. It takes a burst command (base address, length) and issues consecutive reads with address wrap-around. Returned words pass through a small internal buffer and leave on a valid/ready stream, so a slow consumer throttles RAM reads without data loss. One clock domain: the RAM read port is clocked by the same clock as this block.

---
 rtl/ram_burst_reader_if.sv | 32 +++
 rtl/ram_burst_reader.sv | 125 ++++++++++++
 tb/tb_ram_burst_reader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_reader_if.sv
// Bundle of the command, RAM read-port and output-stream signals of ram_burst_reader.
// slave  : the burst reader itself (takes commands, drives the RAM read port and the stream).
// master : the environment (issues commands, returns RAM data, consumes the stream).
interface ram_burst_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  // command side
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   burst_len;
  logic              busy;
  logic              done;
  // RAM read port
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  // output stream
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  start, base_addr, burst_len, rd_data, m_ready,
    output busy, done, rd_en, rd_addr, m_data, m_valid
  );

  modport master (
    output start, base_addr, burst_len, rd_data, m_ready,
    input  busy, done, rd_en, rd_addr, m_data, m_valid
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read sequencer: issues consecutive, wrapping RAM reads and streams the words out.
// Latency: start edge E issues the first read, word enters the buffer at E+2, m_valid after E+2.
// Backpressure: reads only issue while buffered + in-flight words fit the return buffer.
// Ports: clk, rst (sync, active high); bus (slave modport): start/base_addr/burst_len in,
//   busy/done out; rd_en/rd_addr out, rd_data in; m_data/m_valid out, m_ready in.
module ram_burst_reader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int BUF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  ram_burst_reader_if.slave  bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] BUF_LIM = (CNT_W+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   remaining, remaining_nxt;
  logic [ADDR_W-1:0] next_addr, next_addr_nxt;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              cap_vld;   // RAM sampled rd_en last edge: rd_data is valid now
  logic              done_q, done_nxt;

  logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push, pop;
  logic [CNT_W:0]    credit_used;

  assign push = cap_vld;
  assign pop  = bus.m_valid && bus.m_ready;

  // Words in flight are the read issued last edge (rd_en_q) and the one being
  // returned now (cap_vld); counting both keeps the capture path overflow-free.
  assign credit_used = {1'b0, count} + (CNT_W+1)'(rd_en_q) + (CNT_W+1)'(cap_vld)
                       - (CNT_W+1)'(pop);

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    next_addr_nxt = next_addr;
    issue_addr    = next_addr;
    issue         = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.burst_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            // First read goes out on the accepting edge; the buffer is empty in IDLE.
            issue         = 1'b1;
            issue_addr    = bus.base_addr;
            next_addr_nxt = bus.base_addr + ADDR_W'(1);
            remaining_nxt = bus.burst_len - (ADDR_W+1)'(1);
            state_nxt     = (bus.burst_len == (ADDR_W+1)'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (remaining != '0 && credit_used < BUF_LIM) begin
          issue         = 1'b1;
          next_addr_nxt = next_addr + ADDR_W'(1);
          remaining_nxt = remaining - (ADDR_W+1)'(1);
          if (remaining == (ADDR_W+1)'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && count == CNT_W'(1) && !rd_en_q && !cap_vld) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      next_addr <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      cap_vld   <= 1'b0;  // drops any read still in flight
      done_q    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      next_addr <= next_addr_nxt;
      rd_en_q   <= issue;
      if (issue) rd_addr_q <= issue_addr;
      cap_vld   <= rd_en_q;
      done_q    <= done_nxt;
      if (push) begin
        buf_mem[wr_ptr] <= bus.rd_data;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.m_data  = buf_mem[rd_ptr];
  assign bus.m_valid = (count != '0);
endmodule

// File: tb/tb_ram_burst_reader.sv
// Testbench for ram_burst_reader: table of burst commands with hand-computed expected
// words, done latency and peak occupancy, plus hand-written reset sequences.
// Ports: drives clk/rst and the master side of ram_burst_reader_if; models the RAM.
module tb_ram_burst_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ram_burst_reader_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  ram_burst_reader #(.DATA_W(16), .ADDR_W(3), .BUF_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM read port: one-cycle read latency
  logic [15:0] ram [8];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];

  typedef struct {
    logic [2:0]       base;
    logic [3:0]       len;
    int               mode;     // 0: m_ready=1; 1: low 10 cycles then 1/0 toggling
    int               mid_k;    // cycle in which a second start is pulsed, -1 = none
    int               n;        // expected words
    logic [7:0][15:0] d;        // expected words in order
    int               first_k;  // sample index of first m_valid (-1 = never)
    int               done_k;   // sample index where done is seen
    int               occ;      // peak issued-but-not-consumed words
  } vec_t;

  vec_t vecs[8];

  function automatic logic [7:0][15:0] pk8(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7);
    logic [7:0][15:0] r;
    r[0] = w0; r[1] = w1; r[2] = w2; r[3] = w3;
    r[4] = w4; r[5] = w5; r[6] = w6; r[7] = w7;
    return r;
  endfunction

  function automatic vec_t mk(input logic [2:0] base, input logic [3:0] len, input int mode,
                              input int mid_k, input int n, input logic [7:0][15:0] d,
                              input int first_k, input int done_k, input int occ);
    vec_t v;
    v.base = base; v.len = len; v.mode = mode; v.mid_k = mid_k; v.n = n; v.d = d;
    v.first_k = first_k; v.done_k = done_k; v.occ = occ;
    return v;
  endfunction

  function automatic logic ready_at(input int mode, input int k);
    if (mode == 0) return 1'b1;
    return (k >= 10) && (((k - 10) % 2) == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n_rd = 0, n_pop = 0, n_done = 0, done_k = -1, first_k = -1, max_occ = 0, occ;
    bit stall = 1'b0;
    logic [15:0] stall_dat = '0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = v.base; bus.burst_len = v.len;
    bus.m_ready = ready_at(v.mode, -1);
    @(posedge clk); #1;   // start edge
    bus.start = 1'b0;
    bus.m_ready = ready_at(v.mode, 0);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0 && v.len != 0) chk($sformatf("busy_after_start[%0d]", idx), bus.busy, 1);
      if (stall) begin
        chk($sformatf("stall_valid[%0d]", idx), bus.m_valid, 1);
        chk($sformatf("stall_data[%0d]", idx), bus.m_data, stall_dat);
      end
      stall     = bus.m_valid && !bus.m_ready;
      stall_dat = bus.m_data;
      if (bus.rd_en) begin
        chk($sformatf("rd_addr[%0d.%0d]", idx, n_rd), bus.rd_addr, (v.base + n_rd) % 8);
        n_rd++;
      end
      occ = n_rd - n_pop;
      if (occ > max_occ) max_occ = occ;
      if (bus.m_valid && first_k < 0) first_k = k;
      if (bus.m_valid && bus.m_ready) begin
        if (n_pop < v.n) chk($sformatf("m_data[%0d.%0d]", idx, n_pop), bus.m_data, v.d[n_pop]);
        n_pop++;
      end
      if (bus.done) begin
        n_done++;
        if (done_k < 0) begin
          done_k = k;
          chk($sformatf("busy_at_done[%0d]", idx), bus.busy, 0);
        end
      end
      if (done_k >= 0 && k >= done_k + 2) break;
      @(posedge clk); #1;
      bus.m_ready = ready_at(v.mode, k + 1);
      bus.start   = (k + 1 == v.mid_k);
      if (k + 1 == v.mid_k) begin
        bus.base_addr = 3'd5; bus.burst_len = 4'd3;
      end
    end
    chk($sformatf("done_cycle[%0d]", idx), done_k, v.done_k);
    chk($sformatf("done_pulses[%0d]", idx), n_done, 1);
    chk($sformatf("rd_en_count[%0d]", idx), n_rd, v.len);
    chk($sformatf("word_count[%0d]", idx), n_pop, v.n);
    chk($sformatf("first_valid[%0d]", idx), first_k, v.first_k);
    chk($sformatf("peak_occ[%0d]", idx), max_occ, v.occ);
    chk($sformatf("busy_end[%0d]", idx), bus.busy, 0);
  endtask

  initial begin
    int n_hs, n_done;
    ram[0] = 16'hA1A1; ram[1] = 16'hB2B2; ram[2] = 16'hC3C3; ram[3] = 16'hD4D4;
    ram[4] = 16'hE5E5; ram[5] = 16'h5555; ram[6] = 16'h1111; ram[7] = 16'h2222;

    vecs[0] = mk(3'd0, 4'd5, 0, -1, 5, pk8(16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4, 16'hE5E5,
                 16'h0, 16'h0, 16'h0), 2, 7, 3);
    vecs[1] = mk(3'd6, 4'd4, 0, -1, 4, pk8(16'h1111, 16'h2222, 16'hA1A1, 16'hB2B2, 16'h0,
                 16'h0, 16'h0, 16'h0), 2, 6, 3);
    vecs[2] = mk(3'd0, 4'd8, 1, -1, 8, pk8(16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4, 16'hE5E5,
                 16'h5555, 16'h1111, 16'h2222), 2, 25, 4);
    vecs[3] = mk(3'd0, 4'd0, 0, -1, 0, pk8(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                 16'h0), -1, 0, 0);
    vecs[4] = mk(3'd0, 4'd5, 0, 2, 5, pk8(16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4, 16'hE5E5,
                 16'h0, 16'h0, 16'h0), 2, 7, 3);
    vecs[5] = mk(3'd3, 4'd1, 0, -1, 1, pk8(16'hD4D4, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                 16'h0, 16'h0), 2, 3, 1);
    vecs[6] = mk(3'd2, 4'd8, 0, -1, 8, pk8(16'hC3C3, 16'hD4D4, 16'hE5E5, 16'h5555, 16'h1111,
                 16'h2222, 16'hA1A1, 16'hB2B2), 2, 10, 3);
    vecs[7] = mk(3'd7, 4'd2, 0, -1, 2, pk8(16'h2222, 16'hA1A1, 16'h0, 16'h0, 16'h0, 16'h0,
                 16'h0, 16'h0), 2, 4, 2);

    // reset with random command/stream inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.start     = 1'($urandom_range(0, 1));
      bus.base_addr = 3'($urandom_range(0, 7));
      bus.burst_len = 4'($urandom_range(0, 8));
      bus.m_ready   = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_rd_en", bus.rd_en, 0);
      chk("reset_rd_addr", bus.rd_addr, 0);
      chk("reset_m_valid", bus.m_valid, 0);
      chk("reset_m_data", bus.m_data, 0);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // reset after the second handshake of a 5-word burst
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = 3'd0; bus.burst_len = 4'd5; bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_hs = 0; n_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        if (n_hs == 0) chk("abort_word0", bus.m_data, 16'hA1A1);
        if (n_hs == 1) chk("abort_word1", bus.m_data, 16'hB2B2);
        n_hs++;
      end
      if (bus.done) n_done++;
      @(posedge clk); #1;
      if (k == 3) begin rst = 1'b1; bus.m_ready = 1'b0; end
      if (k == 4) rst = 1'b0;
    end
    @(negedge clk);
    chk("abort_handshakes", n_hs, 2);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd_en", bus.rd_en, 0);
    chk("abort_rd_addr", bus.rd_addr, 0);
    chk("abort_m_valid", bus.m_valid, 0);
    chk("abort_m_data", bus.m_data, 0);
    bus.m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (bus.done) n_done++;
      chk("abort_idle_valid", bus.m_valid, 0);
      chk("abort_idle_rd_en", bus.rd_en, 0);
      @(negedge clk);
    end
    chk("abort_no_done", n_done, 0);
    run_vec(mk(3'd3, 4'd2, 0, -1, 2, pk8(16'hD4D4, 16'hE5E5, 16'h0, 16'h0, 16'h0, 16'h0,
               16'h0, 16'h0), 2, 4, 2), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
